dec_key_schedule: RTL and testbench

- Upstream neighbour of the decryption round datapath. Expands one 128-bit AES cipher key into all 11 round keys (round 0..10) and stores them.
- Serves the stored keys in decryption order (10 down to 0), one per request, on a valid/request handshake.
- A decryption controller pulls one key per round and presents it to the round datapath as its round key.
- Stored keys persist, so consecutive blocks under the same key cost no re-expansion.

---
 rtl/aes_pkg.sv | 34 +++
 rtl/aes_sbox.sv | 33 +++
 rtl/dec_key_schedule.sv | 134 +++++++++++++
 tb/tb_dec_key_schedule.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// aes_pkg : AES-128 constants, round-key type and key-schedule state encoding
// Rev 1.0
// ============================================================================
package aes_pkg;

    localparam int NR = 10;

    typedef logic [127:0] round_key_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } ks_state_e;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Round constant for expansion step i (1..NR); other indices are unused.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        r = 8'h00;
        if (i >= 4'd1 && i <= 4'd10) begin
            r = RCON[i - 4'd1];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// aes_sbox : combinational AES forward S-box (one byte)
// Rev 1.0
// ============================================================================
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX[in_byte];

endmodule
`default_nettype wire

// File: rtl/dec_key_schedule.sv
`default_nettype none
// ============================================================================
// dec_key_schedule : AES-128 key expansion with round keys served 10 -> 0
// Optional zeroize input when DEC_KS_ZEROIZE_EN is defined.   Rev 1.0
// ============================================================================
module dec_key_schedule
    import aes_pkg::*;
#(
    parameter int NR  = aes_pkg::NR,
    parameter int RKW = 128
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [RKW-1:0] key_in,
    input  logic           key_load,
`ifdef DEC_KS_ZEROIZE_EN
    input  logic           zeroize,
`endif
    output logic           key_ready,
    input  logic           rk_req,
    output logic           rk_valid,
    output logic [RKW-1:0] round_key,
    output logic [3:0]     round_idx,
    output logic           last_key
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_EXPAND = EXPAND;
    localparam logic [1:0] S_READY  = READY;
    localparam logic [3:0] TOP_IDX  = 4'(NR);

    logic [1:0]     state;
    logic [3:0]     cnt;
    logic [3:0]     ptr;
    round_key_t     slots [0:NR];
    round_key_t     work;
    round_key_t     next_key;
    logic           clear;
    logic           load_accept;
    logic           expand_step;
    logic           serve_accept;
    logic [31:0]    rot_word;
    logic [31:0]    sub_word;
    logic [31:0]    temp_word;

`ifdef DEC_KS_ZEROIZE_EN
    assign clear = !rst_n || zeroize;
`else
    assign clear = !rst_n;
`endif

    assign key_ready    = (state == S_READY);
    assign load_accept  = !clear && key_load && (state != S_EXPAND);
    assign expand_step  = !clear && (state == S_EXPAND);
    // A load in READY pre-empts a same-cycle request.
    assign serve_accept = !clear && (state == S_READY) && rk_req && !key_load;

    // work always holds the previously generated round key (word 3 in [31:0]).
    assign rot_word = {work[23:0], work[31:24]};

    generate
        for (genvar b = 0; b < 4; b++) begin : g_subword
            aes_sbox u_sbox (
                .in_byte  (rot_word[8*b +: 8]),
                .out_byte (sub_word[8*b +: 8])
            );
        end
    endgenerate

    assign temp_word        = sub_word ^ {rcon(cnt), 24'h000000};
    assign next_key[127:96] = work[127:96] ^ temp_word;
    assign next_key[95:64]  = work[95:64]  ^ next_key[127:96];
    assign next_key[63:32]  = work[63:32]  ^ next_key[95:64];
    assign next_key[31:0]   = work[31:0]   ^ next_key[63:32];

    // Key storage survives reset unless zeroize support is built in.
    always_ff @(posedge clk) begin
`ifdef DEC_KS_ZEROIZE_EN
        if (clear) begin
            for (int k = 0; k <= NR; k++) begin
                slots[k] <= '0;
            end
            work <= '0;
        end else
`endif
        if (load_accept) begin
            slots[0] <= key_in;
            work     <= key_in;
        end else if (expand_step) begin
            slots[cnt] <= next_key;
            work       <= next_key;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            ptr       <= TOP_IDX;
            rk_valid  <= 1'b0;
            last_key  <= 1'b0;
            round_key <= '0;
            round_idx <= TOP_IDX;
        end else begin
            rk_valid <= serve_accept;
            last_key <= serve_accept && (ptr == 4'd0);
            if (serve_accept) begin
                round_key <= slots[ptr];
                round_idx <= ptr;
                ptr       <= (ptr == 4'd0) ? TOP_IDX : ptr - 4'd1;
            end
            case (state)
                S_IDLE, S_READY: begin
                    if (key_load) begin
                        state <= S_EXPAND;
                        cnt   <= 4'd1;
                        ptr   <= TOP_IDX;
                    end
                end
                S_EXPAND: begin
                    if (cnt == TOP_IDX) begin
                        state <= S_READY;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dec_key_schedule.sv
`default_nettype none
// ============================================================================
// tb_dec_key_schedule : directed + randomized bench with FIPS-197 reference
// Rev 1.0
// ============================================================================
module tb_dec_key_schedule;

    logic         clk;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_load;
    logic         key_ready;
    logic         rk_req;
    logic         rk_valid;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         last_key;
`ifdef DEC_KS_ZEROIZE_EN
    logic         zeroize;
`endif

    int n_tests;
    int n_fail;

    logic [7:0]   sb [0:255];
    logic [127:0] rk [0:10];

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

    dec_key_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_load  (key_load),
`ifdef DEC_KS_ZEROIZE_EN
        .zeroize   (zeroize),
`endif
        .key_ready (key_ready),
        .rk_req    (rk_req),
        .rk_valid  (rk_valid),
        .round_key (round_key),
        .round_idx (round_idx),
        .last_key  (last_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // GF(2^8) arithmetic for an S-box derived from first principles.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] a);
        return {a[6:0], a[7]};
    endfunction

    function automatic logic [7:0] calc_sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] r;
        inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        end
        s = inv;
        r = inv;
        for (int i = 0; i < 4; i++) begin
            r = rotl1(r);
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    task automatic build_ref(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !key_ready; i++) tick();
        check("ready_timeout", 128'(key_ready), 128'd1);
    endtask

    // Serve a full block (11 keys, 10 -> 0) back to back and check each.
    task automatic serve_block(input string tag);
        rk_req = 1'b1;
        for (int j = 0; j < 11; j++) begin
            tick();
            check({tag, "_valid"}, 128'(rk_valid), 128'd1);
            check({tag, "_idx"},   128'(round_idx), 128'(10 - j));
            check({tag, "_key"},   round_key, rk[10 - j]);
            check({tag, "_last"},  128'(last_key), 128'(j == 10));
        end
        rk_req = 1'b0;
    endtask

    initial begin
        int          ptr;
        logic        req;
        logic        seen;
        logic [127:0] held;
        logic [127:0] rkey;

        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        key_in   = '0;
        key_load = 1'b0;
        rk_req   = 1'b0;
`ifdef DEC_KS_ZEROIZE_EN
        zeroize  = 1'b0;
`endif
        for (int i = 0; i < 256; i++) sb[i] = calc_sbox(8'(i));

        // Reset state
        tick();
        tick();
        check("rst_ready", 128'(key_ready), 128'd0);
        check("rst_valid", 128'(rk_valid), 128'd0);
        check("rst_last",  128'(last_key), 128'd0);
        check("rst_key",   round_key, 128'd0);
        check("rst_idx",   128'(round_idx), 128'd10);
        rst_n = 1'b1;
        tick();

        // Key A: expansion timing, requests and a stray load during EXPAND
        build_ref(KEY_A);
        do_load(KEY_A);
        rk_req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            if (c == 3) begin
                key_in   = KEY_B;
                key_load = 1'b1;
            end
            tick();
            key_load = 1'b0;
            check("exp_ready", 128'(key_ready), 128'd0);
            check("exp_valid", 128'(rk_valid), 128'd0);
        end
        tick();
        check("ready_at_10", 128'(key_ready), 128'd1);
        check("no_valid_from_expand_req", 128'(rk_valid), 128'd0);
        for (int j = 0; j < 11; j++) begin
            tick();
            check("a_valid", 128'(rk_valid), 128'd1);
            check("a_idx",   128'(round_idx), 128'(10 - j));
            check("a_key",   round_key, rk[10 - j]);
            check("a_last",  128'(last_key), 128'(j == 10));
            if (j == 0)  check("a_fips_r10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
            if (j == 9)  check("a_fips_r1",  round_key, 128'ha0fafe1788542cb123a339392a6c7605);
            if (j == 10) check("a_fips_r0",  round_key, KEY_A);
        end
        rk_req = 1'b0;
        tick();
        check("idle_valid", 128'(rk_valid), 128'd0);
        check("hold_key",   round_key, KEY_A);
        check("idle_last",  128'(last_key), 128'd0);

        // key_load and rk_req together in READY: load wins
        build_ref(KEY_B);
        key_in   = KEY_B;
        key_load = 1'b1;
        rk_req   = 1'b1;
        tick();
        key_load = 1'b0;
        rk_req   = 1'b0;
        check("load_req_valid", 128'(rk_valid), 128'd0);
        check("load_req_ready", 128'(key_ready), 128'd0);
        wait_ready();
        rk_req = 1'b1;
        tick();
        rk_req = 1'b0;
        check("b_valid", 128'(rk_valid), 128'd1);
        check("b_idx",   128'(round_idx), 128'd10);
        check("b_fips_r10", round_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        tick();
        check("b_valid_drop", 128'(rk_valid), 128'd0);

        // Wrap: 12 consecutive requests, reloading to reset the pointer
        do_load(KEY_B);
        wait_ready();
        rk_req = 1'b1;
        for (int n = 0; n < 12; n++) begin
            tick();
            check("wrap_valid", 128'(rk_valid), 128'd1);
            check("wrap_idx",   128'(round_idx), 128'((n == 11) ? 10 : 10 - n));
            check("wrap_key",   round_key, rk[(n == 11) ? 10 : 10 - n]);
        end
        rk_req = 1'b0;

        // Random keys with random request patterns against the model
        for (int t = 0; t < 3; t++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            build_ref(rkey);
            do_load(rkey);
            wait_ready();
            ptr  = 10;
            seen = 1'b0;
            held = '0;
            for (int c = 0; c < 40; c++) begin
                req    = 1'($urandom_range(0, 1));
                rk_req = req;
                tick();
                check("rnd_valid", 128'(rk_valid), 128'(req));
                if (req) begin
                    check("rnd_idx",  128'(round_idx), 128'(ptr));
                    check("rnd_key",  round_key, rk[ptr]);
                    check("rnd_last", 128'(last_key), 128'(ptr == 0));
                    held = rk[ptr];
                    seen = 1'b1;
                    ptr  = (ptr == 0) ? 10 : ptr - 1;
                end else if (seen) begin
                    check("rnd_hold", round_key, held);
                end
            end
            rk_req = 1'b0;
        end

        // Reset in the middle of expansion
        build_ref(KEY_A);
        do_load(KEY_A);
        for (int c = 0; c < 4; c++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_ready", 128'(key_ready), 128'd0);
        check("mid_rst_valid", 128'(rk_valid), 128'd0);
        check("mid_rst_idx",   128'(round_idx), 128'd10);
        rk_req = 1'b1;
        tick();
        rk_req = 1'b0;
        check("mid_rst_req_dropped", 128'(rk_valid), 128'd0);
        check("mid_rst_stays_idle",  128'(key_ready), 128'd0);
        do_load(KEY_A);
        wait_ready();
        serve_block("reload");

`ifdef DEC_KS_ZEROIZE_EN
        // Zeroize beats a simultaneous load and request
        key_in   = KEY_B;
        zeroize  = 1'b1;
        key_load = 1'b1;
        rk_req   = 1'b1;
        tick();
        zeroize  = 1'b0;
        key_load = 1'b0;
        rk_req   = 1'b0;
        check("zero_ready", 128'(key_ready), 128'd0);
        check("zero_valid", 128'(rk_valid), 128'd0);
        check("zero_key",   round_key, 128'd0);
        for (int k = 0; k < 11; k++) check("zero_slot", dut.slots[k], 128'd0);
        tick();
        check("zero_stays_idle", 128'(key_ready), 128'd0);
        do_load(KEY_A);
        wait_ready();
        serve_block("post_zero");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
